// File: rtl/calc_port_responder.sv
// Single-port calculator responder: cmd+op1, then op2, response after LATENCY cycles.
// Optional shifter for commands 5/6 is enabled by defining CALC_SHIFT_EN.
module calc_port_responder #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        drop_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OPND2 = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] RC_NONE = 2'd0;
  localparam logic [1:0] RC_OK   = 2'd1;
  localparam logic [1:0] RC_ERR  = 2'd2;

  // Ports use [0:N] numbering; internally everything is [N:0] with the same MSB.
  logic [3:0]  cmd_w;
  logic [31:0] data_w;
  assign cmd_w  = req_cmd_in;
  assign data_w = req_data_in;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  rc_q, rc_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] odata_q, odata_d;
  logic        drop_q, drop_d;

  logic [32:0] sum;
  logic [31:0] calc_data;
  logic [1:0]  calc_rc;

  // Result is computed from the latched command/op1 and op2 still on the bus.
  always_comb begin
    sum       = {1'b0, op1_q} + {1'b0, data_w};
    calc_rc   = RC_ERR;
    calc_data = '0;
    case (cmd_q)
      4'd1: begin
        if (!sum[32]) begin
          calc_rc   = RC_OK;
          calc_data = sum[31:0];
        end
      end
      4'd2: begin
        if (data_w <= op1_q) begin
          calc_rc   = RC_OK;
          calc_data = op1_q - data_w;
        end
      end
`ifdef CALC_SHIFT_EN
      4'd5: begin
        calc_rc   = RC_OK;
        calc_data = op1_q << data_w[4:0];
      end
      4'd6: begin
        calc_rc   = RC_OK;
        calc_data = op1_q >> data_w[4:0];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    res_d   = res_q;
    rc_d    = rc_q;
    resp_d  = RC_NONE;
    odata_d = '0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_w != 4'd0) begin
          cmd_d   = cmd_w;
          op1_d   = data_w;
          state_d = OPND2;
        end
      end
      OPND2: begin
        res_d   = calc_data;
        rc_d    = calc_rc;
        cnt_d   = CNT_LOAD;
        state_d = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        drop_d = (cmd_w != 4'd0);
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        resp_d  = rc_q;
        odata_d = (rc_q == RC_OK) ? res_q : '0;
        // A command here overlaps the response and starts the next request.
        if (cmd_w != 4'd0) begin
          cmd_d   = cmd_w;
          op1_d   = data_w;
          state_d = OPND2;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      op1_q   <= '0;
      res_q   <= '0;
      rc_q    <= RC_NONE;
      resp_q  <= RC_NONE;
      odata_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      res_q   <= res_d;
      rc_q    <= rc_d;
      resp_q  <= resp_d;
      odata_q <= odata_d;
      drop_q  <= drop_d;
    end
  end

  assign out_resp = resp_q;
  assign out_data = odata_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder at LATENCY=3; shift checks follow CALC_SHIFT_EN.
module tb_calc_port_responder;

  localparam int LAT = 3;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [0:3]  req_cmd_in = '0;
  logic [0:31] req_data_in = '0;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        drop_err;

  int total = 0;
  int bad   = 0;

  calc_port_responder #(.LATENCY(LAT)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .drop_err    (drop_err)
  );

  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    req_cmd_in  = cmd;
    req_data_in = a;
    tick();
    req_cmd_in  = 4'd0;
    req_data_in = b;
    tick();
    req_data_in = '0;
  endtask

  task automatic run(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] er, input logic [31:0] ed, input string tag);
    send(cmd, a, b);
    repeat (LAT - 1) begin
      tick();
      chk({tag, "_early"}, 32'(out_resp), 32'd0);
    end
    tick();
    chk({tag, "_resp"}, 32'(out_resp), 32'(er));
    chk({tag, "_data"}, out_data, ed);
    tick();
    chk({tag, "_clear"}, 32'(out_resp), 32'd0);
  endtask

  initial begin
    // reset held with a live command
    reset = 1'b0;
    req_cmd_in = 4'd1;
    req_data_in = 32'h5;
    repeat (3) begin
      tick();
      chk("rst_resp", 32'(out_resp), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_drop", 32'(drop_err), 32'd0);
    end
    reset = 1'b1;
    req_cmd_in = 4'd0;
    req_data_in = '0;
    repeat (6) begin
      tick();
      chk("post_rst_resp", 32'(out_resp), 32'd0);
    end

    run(4'd1, 32'h5, 32'h7, 2'd1, 32'hC, "add");
    run(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'h0, "add_ovf");
    run(4'd1, 32'hFFFF_FFFE, 32'h1, 2'd1, 32'hFFFF_FFFF, "add_max");
    run(4'd2, 32'h10, 32'h10, 2'd1, 32'h0, "sub_eq");
    run(4'd2, 32'h3, 32'h4, 2'd2, 32'h0, "sub_unf");
    run(4'd2, 32'h9, 32'h4, 2'd1, 32'h5, "sub");
`ifdef CALC_SHIFT_EN
    run(4'd5, 32'h1, 32'h24, 2'd1, 32'h10, "shl");
    run(4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h1, "shr");
`else
    run(4'd5, 32'h1, 32'h24, 2'd2, 32'h0, "shl_off");
    run(4'd6, 32'h8000_0000, 32'd31, 2'd2, 32'h0, "shr_off");
`endif
    run(4'd3, 32'h1, 32'h1, 2'd2, 32'h0, "inv3");
    run(4'd15, 32'h1, 32'h1, 2'd2, 32'h0, "inv15");

    // back-to-back: second command presented during the RESP cycle
    send(4'd1, 32'h5, 32'h7);
    tick();
    chk("b2b_w1", 32'(out_resp), 32'd0);
    tick();
    chk("b2b_w2", 32'(out_resp), 32'd0);
    req_cmd_in  = 4'd2;
    req_data_in = 32'h20;
    tick();
    chk("b2b_a_resp", 32'(out_resp), 32'd1);
    chk("b2b_a_data", out_data, 32'hC);
    req_cmd_in  = 4'd0;
    req_data_in = 32'h8;
    tick();
    req_data_in = '0;
    chk("b2b_gap0", 32'(out_resp), 32'd0);
    repeat (2) begin
      tick();
      chk("b2b_gap", 32'(out_resp), 32'd0);
    end
    tick();
    chk("b2b_b_resp", 32'(out_resp), 32'd1);
    chk("b2b_b_data", out_data, 32'h18);
    tick();
    chk("b2b_clear", 32'(out_resp), 32'd0);

    // conflicting command during WAIT
    send(4'd1, 32'h100, 32'h23);
    req_cmd_in = 4'd4;
    tick();
    req_cmd_in = 4'd0;
    chk("drop_pulse", 32'(drop_err), 32'd1);
    chk("drop_resp", 32'(out_resp), 32'd0);
    tick();
    chk("drop_end", 32'(drop_err), 32'd0);
    tick();
    chk("drop_a_resp", 32'(out_resp), 32'd1);
    chk("drop_a_data", out_data, 32'h123);
    tick();
    chk("drop_clear", 32'(out_resp), 32'd0);

    // reset while waiting aborts the request
    send(4'd1, 32'h1, 32'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (6) begin
      tick();
      chk("abort_resp", 32'(out_resp), 32'd0);
      chk("abort_drop", 32'(drop_err), 32'd0);
    end
    run(4'd1, 32'h40, 32'h2, 2'd1, 32'h42, "fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
# calc_port_responder

Single-port calculator responder: the DUT-side end of the request/response protocol used by the calculator test environment. It samples a command and operand 1 on one cycle and operand 2 on the next. It computes add, subtract or shift, and returns a one-cycle response code with result data after a fixed latency. It is the building block for a four-port behavioral reference model and standalone port bring-up.

## Interface

Parameters:
- `LATENCY`, default 3: cycles from the operand-2 sample edge to the edge that presents the response. Legal range 1..15.

Ports:
- `c_clk` in 1: the single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset, sampled on the `c_clk` rising edge.
- `req_cmd_in` in [0:3]: command. 0 = no-op, 1 = add, 2 = subtract, 5 = shift left, 6 = shift right. All other codes are invalid.
- `req_data_in` in [0:31]: operand 1 in the command cycle, operand 2 in the following cycle.
- `out_resp` out [0:1]: response code. 0 = none, 1 = success, 2 = overflow, underflow or invalid command. Code 3 is never driven.
- `out_data` out [0:31]: result; nonzero only while `out_resp` = 1.
- `drop_err` out 1: one-cycle pulse when a command arrives while a request is in progress.

## Operation

- FSM states: IDLE, OPND2, WAIT, RESP.
- IDLE:
  - `req_cmd_in` ≠ 0 → latch cmd and op1 → OPND2.
  - `req_cmd_in` = 0 → stay in IDLE.
- OPND2:
  - Latch op2 from `req_data_in`.
  - Compute and register the result and response code.
  - Load the wait counter with `LATENCY`−1.
  - Go to RESP if `LATENCY` = 1, else to WAIT.
  - `req_cmd_in` is ignored in this cycle; it is the operand cycle.
- WAIT: decrement the counter; at 0 → RESP.
- RESP: drive `out_resp`/`out_data` for exactly this cycle.
  - `req_cmd_in` ≠ 0 here is accepted as a new request → OPND2.
  - Otherwise → IDLE.
- Busy conflict: `req_cmd_in` ≠ 0 in WAIT → command discarded, `drop_err` = 1 the next cycle, FSM unaffected.
- Arithmetic (unsigned 32-bit):
  - add: 33-bit sum; carry out → resp 2, data 0.
  - sub: op2 > op1 → resp 2, data 0. op1 = op2 → resp 1, data 0.
  - shift left/right: amount = op2[27:31] (0..31). Vacated bits are zero-filled; shifted-out bits are discarded. Always resp 1.
  - invalid cmd (3, 4, 7..15): resp 2, data 0.
- `out_data` is forced to 0 whenever `out_resp` ≠ 1.

## Timing

- Reset (`reset` = 0 at an edge) → FSM = IDLE, `out_resp` = 0, `out_data` = 0, `drop_err` = 0, counter = 0, latched operands = 0.
- Reset mid-operation aborts the request; no response is ever produced for it.
- Command sampled at edge k, op2 at edge k+1 → response registered at edge k+1+`LATENCY` and held for one cycle.
- Minimum request spacing: the new command can coincide with the previous response cycle, giving a throughput of one request per `LATENCY`+1 cycles.
- `drop_err` is registered: a conflicting command at edge j gives a pulse in the cycle following edge j.
- All outputs are registers; there is no combinational path from inputs to outputs.

## Configuration

- `CALC_SHIFT_EN` defined: commands 5 and 6 perform shifts as specified above.
- Not defined: commands 5 and 6 are invalid (resp 2, data 0), no shifter logic is synthesized, and the response latency is unchanged.

## Test plan

- Reset behaviour: hold `reset` = 0 for 3 cycles with `req_cmd_in` = 1 → `out_resp` = 0, `out_data` = 0, `drop_err` = 0 throughout. After release, no response is produced for the ignored command.
- Add, `LATENCY` = 3: cmd 1, op1 0x0000_0005, op2 0x0000_0007 → `out_resp` = 1, `out_data` = 0x0000_000C at edge k+4 for one cycle. Add 0xFFFF_FFFF + 0x1 → resp 2, data 0.
- Subtract: 0x10 − 0x10 → resp 1, data 0. 0x3 − 0x4 → resp 2, data 0.
- Shift, `CALC_SHIFT_EN` defined: cmd 5, op1 0x0000_0001, op2 0x0000_0024 (amount 4) → resp 1, data 0x0000_0010. Cmd 6, op1 0x8000_0000, op2 31 → data 0x0000_0001. Macro undefined: cmd 5 → resp 2, data 0.
- Back-to-back and conflict:
  - A command issued in the RESP cycle is accepted; its response arrives `LATENCY`+1 cycles later.
  - A command issued in WAIT raises `drop_err` for one cycle and does not change the pending response.
- Invalid and mid-operation reset:
  - cmd 3 → resp 2, data 0.
  - Assert reset during WAIT → no response, FSM back in IDLE, and a fresh add completes normally.
